// File: rtl/acc_cpu_core_if.sv
// Instruction-fetch handshake between acc_cpu_core and its program memory.
// The core drives req/addr; the memory answers with rdata/valid, possibly in the same cycle.
interface acc_cpu_core_if #(
    parameter int PC_W    = 11,
    parameter int INSTR_W = 14
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: literal ALU ops on W, GOTO, SLEEP/wake, Z/C flags,
// illegal-opcode pulse, with instructions fetched over a variable-latency req/valid port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FETCH  | imem_req high at PC; on valid capture IR, PC+1, go EXEC
// S_EXEC   | execute IR, pulse retire; SLEEP goes HALTED, else FETCH
// S_HALTED | everything frozen until wake
module acc_cpu_core #(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 11,
    parameter int INSTR_W   = 14,
    parameter int RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    acc_cpu_core_if.master    imem,
    input  logic              wake,
    output logic [DATA_W-1:0] w_q_out,
    output logic              status_z,
    output logic              status_c,
    output logic [PC_W-1:0]   pc_out,
    output logic              halted,
    output logic              retire,
    output logic              illegal_op
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [5:0] OP_MOVLW = 6'b110000;
    localparam logic [5:0] OP_ADDLW = 6'b111110;
    localparam logic [5:0] OP_SUBLW = 6'b111100;
    localparam logic [5:0] OP_ANDLW = 6'b111001;
    localparam logic [5:0] OP_IORLW = 6'b111000;
    localparam logic [5:0] OP_XORLW = 6'b111010;
    localparam logic [INSTR_W-1:0] IR_SLEEP = INSTR_W'(7'h63);
    localparam logic [PC_W-1:0]    PC_RST   = PC_W'(RESET_VEC);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   w_q, w_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;

    logic [5:0]          op6;
    logic [DATA_W-1:0]   lit;
    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;
    logic                is_alu, is_goto, is_nop, is_sleep, dec_illegal;

    assign op6      = ir_q[INSTR_W-1 -: 6];
    assign lit      = ir_q[DATA_W-1:0];
    assign sum_ext  = {1'b0, lit} + {1'b0, w_q};
    assign diff_ext = {1'b0, lit} - {1'b0, w_q};

    always_comb begin
        is_alu      = (op6 == OP_MOVLW) || (op6 == OP_ADDLW) || (op6 == OP_SUBLW) ||
                      (op6 == OP_ANDLW) || (op6 == OP_IORLW) || (op6 == OP_XORLW);
        is_goto     = (ir_q[INSTR_W-1 -: 2] == 2'b10);
        is_nop      = (ir_q == '0);
        is_sleep    = (ir_q == IR_SLEEP);
        dec_illegal = !(is_alu || is_goto || is_nop || is_sleep);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (imem.imem_valid) state_d = S_EXEC;
            S_EXEC:   state_d = is_sleep ? S_HALTED : S_FETCH;
            S_HALTED: if (wake) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by reset_n so they read idle throughout the reset cycle.
    always_comb begin
        imem.imem_req  = reset_n && (state_q == S_FETCH);
        imem.imem_addr = pc_q;
        retire         = reset_n && (state_q == S_EXEC);
        illegal_op     = reset_n && (state_q == S_EXEC) && dec_illegal;
        halted         = reset_n && (state_q == S_HALTED);
    end

    // imem_rdata is only looked at when valid, so X on an idle bus never reaches IR.
    always_comb begin
        pc_d = pc_q;
        w_d  = w_q;
        z_d  = z_q;
        c_d  = c_q;
        ir_d = ir_q;
        if (state_q == S_FETCH && imem.imem_valid) begin
            ir_d = imem.imem_rdata;
            pc_d = pc_q + PC_W'(1);
        end else if (state_q == S_EXEC) begin
            if (is_goto) begin
                pc_d = ir_q[PC_W-1:0];
            end else begin
                unique case (op6)
                    OP_MOVLW: w_d = lit;
                    OP_ADDLW: begin
                        w_d = sum_ext[DATA_W-1:0];
                        c_d = sum_ext[DATA_W];
                        z_d = (sum_ext[DATA_W-1:0] == '0);
                    end
                    OP_SUBLW: begin
                        w_d = diff_ext[DATA_W-1:0];
                        c_d = ~diff_ext[DATA_W];
                        z_d = (diff_ext[DATA_W-1:0] == '0);
                    end
                    OP_ANDLW: begin
                        w_d = lit & w_q;
                        z_d = ((lit & w_q) == '0);
                    end
                    OP_IORLW: begin
                        w_d = lit | w_q;
                        z_d = ((lit | w_q) == '0);
                    end
                    OP_XORLW: begin
                        w_d = lit ^ w_q;
                        z_d = ((lit ^ w_q) == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= PC_RST;
            w_q  <= '0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            w_q  <= w_d;
            z_q  <= z_d;
            c_q  <= c_d;
            ir_q <= ir_d;
        end
    end

    assign w_q_out  = w_q;
    assign status_z = z_q;
    assign status_c = c_q;
    assign pc_out   = pc_q;

endmodule
